// File: rtl/sim_run_monitor_pkg.sv
// rtl/sim_run_monitor_pkg.sv - shared state/verdict types for the simulation run monitor
package sim_run_monitor_pkg;

   localparam int FAIL_W = 2;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [FAIL_W-1:0] {
      FAIL_NONE    = 2'd0,
      FAIL_CODE    = 2'd1,
      FAIL_TIMEOUT = 2'd2,
      FAIL_HANG    = 2'd3
   } fail_reason_t;

   // Counter width able to hold 0..v-1, never narrower than one bit.
   function automatic int min1_clog2(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/sim_run_monitor_pc_hist.sv
// rtl/sim_run_monitor_pc_hist.sv - ring buffer of recently retired PCs
// Present only in builds with SIM_RUN_MONITOR_PC_HISTORY_EN defined.
module sim_run_monitor_pc_hist #(
   parameter int DEPTH = 8
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic                     i_wr_en,
   input  logic [31:0]              i_wr_pc,
   input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
   output logic [31:0]              o_rd_pc
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] w_rd_addr;

   // Index 0 is the newest entry; the pointer width gives the modulo wrap for free.
   assign w_rd_addr = r_wptr - PTR_W'(1) - i_rd_idx;
   assign o_rd_pc   = r_mem[w_rd_addr];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr <= '0;
      end else if (i_wr_en) begin
         r_mem[r_wptr] <= i_wr_pc;
         r_wptr        <= r_wptr + 1'b1;
      end
   end

endmodule

// File: rtl/sim_run_monitor.sv
// rtl/sim_run_monitor.sv - core reset sequencing, run counters and pass/fail verdict
// Optional PC history buffer enabled by SIM_RUN_MONITOR_PC_HISTORY_EN.
module sim_run_monitor
   import sim_run_monitor_pkg::*;
#(
   parameter int RESET_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int HANG_CYCLES    = 4096,
   parameter int CNT_W          = 64,
   parameter int HIST_DEPTH     = 8
) (
   input  logic                          clock,
   input  logic                          reset_n,
   output logic                          core_reset,
   input  logic                          commit_valid,
   input  logic [31:0]                   commit_pc,
   input  logic                          halt_valid,
   input  logic [31:0]                   halt_code,
   output logic [CNT_W-1:0]              cycle_count,
   output logic [CNT_W-1:0]              inst_count,
   output logic                          done,
   output logic                          pass,
   output logic [1:0]                    fail_reason,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic [31:0]                   hist_pc
);

   localparam int HOLD_W = min1_clog2(RESET_CYCLES);
   localparam int IDLE_W = min1_clog2(HANG_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HANG_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t             r_state;
   fail_reason_t       r_fail;
   logic [HOLD_W-1:0]  r_hold;
   logic [IDLE_W-1:0]  r_idle;
   logic [CNT_W-1:0]   r_cycle;
   logic [CNT_W-1:0]   r_inst;
   logic               r_core_reset;
   logic               r_done;
   logic               r_pass;
   logic               w_hang;
   logic               w_timeout;
   logic               w_hist_wr;

   assign w_hang    = (HANG_CYCLES != 0) && !commit_valid && (r_idle == IDLE_LAST);
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cycle == TO_LAST);
   assign w_hist_wr = (r_state == RUN) && commit_valid;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= HOLD;
         r_hold       <= '0;
         r_idle       <= '0;
         r_cycle      <= '0;
         r_inst       <= '0;
         r_core_reset <= 1'b1;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail       <= FAIL_NONE;
      end else begin
         case (r_state)
            HOLD: begin
               r_hold <= r_hold + 1'b1;
               if (r_hold == HOLD_LAST) begin
                  r_state      <= RUN;
                  r_core_reset <= 1'b0;
               end
            end
            RUN: begin
               // The terminating cycle is still counted, including a coincident commit.
               r_cycle <= r_cycle + 1'b1;
               if (commit_valid) begin
                  r_inst <= r_inst + 1'b1;
                  r_idle <= '0;
               end else begin
                  r_idle <= r_idle + 1'b1;
               end
               if (halt_valid) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_pass  <= (halt_code == 32'd0);
                  r_fail  <= (halt_code == 32'd0) ? FAIL_NONE : FAIL_CODE;
               end else if (w_hang) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_fail  <= FAIL_HANG;
               end else if (w_timeout) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_fail  <= FAIL_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   assign core_reset  = r_core_reset;
   assign cycle_count = r_cycle;
   assign inst_count  = r_inst;
   assign done        = r_done;
   assign pass        = r_pass;
   assign fail_reason = r_fail;

`ifdef SIM_RUN_MONITOR_PC_HISTORY_EN
   sim_run_monitor_pc_hist #(
      .DEPTH (HIST_DEPTH)
   ) u_pc_hist (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_wr_en   (w_hist_wr),
      .i_wr_pc   (commit_pc),
      .i_rd_idx  (hist_idx),
      .o_rd_pc   (hist_pc)
   );
`else
   logic w_unused_hist;
   assign w_unused_hist = ^{commit_pc, hist_idx, w_hist_wr};
   assign hist_pc       = 32'd0;
`endif

endmodule

// File: tb/tb_sim_run_monitor.sv
// tb/tb_sim_run_monitor.sv - directed self-checking bench for sim_run_monitor
// History checks follow SIM_RUN_MONITOR_PC_HISTORY_EN.
module tb_sim_run_monitor;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_pc = 32'd0;
   logic        halt_valid = 1'b0;
   logic [31:0] halt_code = 32'd0;
   logic [1:0]  hist_idx = 2'd0;
   logic        core_reset;
   logic [63:0] cycle_count;
   logic [63:0] inst_count;
   logic        done;
   logic        pass;
   logic [1:0]  fail_reason;
   logic [31:0] hist_pc;

   int tests_run = 0;
   int tests_failed = 0;

   sim_run_monitor #(
      .RESET_CYCLES   (4),
      .TIMEOUT_CYCLES (100),
      .HANG_CYCLES    (16),
      .CNT_W          (64),
      .HIST_DEPTH     (4)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .core_reset   (core_reset),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .halt_valid   (halt_valid),
      .halt_code    (halt_code),
      .cycle_count  (cycle_count),
      .inst_count   (inst_count),
      .done         (done),
      .pass         (pass),
      .fail_reason  (fail_reason),
      .hist_idx     (hist_idx),
      .hist_pc      (hist_pc)
   );

   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic idle_inputs();
      commit_valid = 1'b0;
      halt_valid   = 1'b0;
      halt_code    = 32'd0;
      commit_pc    = 32'd0;
   endtask

   // Leaves the bench at the negedge inside the first RUN cycle.
   task automatic start_run();
      idle_inputs();
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(4);
   endtask

   task automatic test_reset();
      int ones;
      idle_inputs();
      reset_n = 1'b0;
      step(2);
      tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL rst_core_reset: got %0b expected 1", core_reset); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %0b expected 0", done); end
      tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL rst_pass: got %0b expected 0", pass); end
      tests_run++; if (fail_reason !== 2'd0) begin tests_failed++; $display("FAIL rst_fail_reason: got %0d expected 0", fail_reason); end
      tests_run++; if (cycle_count !== 64'd0) begin tests_failed++; $display("FAIL rst_cycle_count: got %0d expected 0", cycle_count); end
      tests_run++; if (inst_count !== 64'd0) begin tests_failed++; $display("FAIL rst_inst_count: got %0d expected 0", inst_count); end
      reset_n = 1'b1;
      commit_valid = 1'b1;
      halt_valid = 1'b1;
      halt_code = 32'h5;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) idle_inputs();
         if (core_reset === 1'b1) ones++;
         if (i < 7) step(1);
      end
      tests_run++; if (ones != 4) begin tests_failed++; $display("FAIL hold_length: got %0d cycles expected 4", ones); end
      tests_run++; if (cycle_count !== 64'd3) begin tests_failed++; $display("FAIL hold_cycle_start: got %0d expected 3", cycle_count); end
      tests_run++; if (inst_count !== 64'd0) begin tests_failed++; $display("FAIL hold_ignores_commit: got %0d expected 0", inst_count); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL hold_ignores_halt: got %0b expected 0", done); end
   endtask

   task automatic test_pass_run();
      start_run();
      for (int k = 0; k < 20; k++) begin
         commit_valid = (k < 10);
         commit_pc = 32'h8000_0000 + 32'(4 * k);
         step(1);
      end
      commit_valid = 1'b0;
      halt_valid = 1'b1;
      halt_code = 32'd0;
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL pass_done_early: got %0b expected 0", done); end
      step(1);
      idle_inputs();
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL pass_done: got %0b expected 1", done); end
      tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL pass_pass: got %0b expected 1", pass); end
      tests_run++; if (fail_reason !== 2'd0) begin tests_failed++; $display("FAIL pass_reason: got %0d expected 0", fail_reason); end
      tests_run++; if (inst_count !== 64'd10) begin tests_failed++; $display("FAIL pass_inst: got %0d expected 10", inst_count); end
      tests_run++; if (cycle_count !== 64'd21) begin tests_failed++; $display("FAIL pass_cycle: got %0d expected 21", cycle_count); end
      tests_run++; if (core_reset !== 1'b0) begin tests_failed++; $display("FAIL pass_core_reset: got %0b expected 0", core_reset); end
      commit_valid = 1'b1;
      halt_valid = 1'b1;
      halt_code = 32'h7;
      step(5);
      idle_inputs();
      tests_run++; if (inst_count !== 64'd10) begin tests_failed++; $display("FAIL frozen_inst: got %0d expected 10", inst_count); end
      tests_run++; if (cycle_count !== 64'd21) begin tests_failed++; $display("FAIL frozen_cycle: got %0d expected 21", cycle_count); end
      tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL frozen_pass: got %0b expected 1", pass); end
      tests_run++; if (fail_reason !== 2'd0) begin tests_failed++; $display("FAIL frozen_reason: got %0d expected 0", fail_reason); end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL frozen_done: got %0b expected 1", done); end
   endtask

   task automatic test_bad_code();
      start_run();
      commit_valid = 1'b1;
      step(3);
      halt_valid = 1'b1;
      halt_code = 32'h5;
      step(1);
      idle_inputs();
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL bad_done: got %0b expected 1", done); end
      tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL bad_pass: got %0b expected 0", pass); end
      tests_run++; if (fail_reason !== 2'd1) begin tests_failed++; $display("FAIL bad_reason: got %0d expected 1", fail_reason); end
      tests_run++; if (inst_count !== 64'd4) begin tests_failed++; $display("FAIL bad_inst_with_halt: got %0d expected 4", inst_count); end
      tests_run++; if (cycle_count !== 64'd4) begin tests_failed++; $display("FAIL bad_cycle: got %0d expected 4", cycle_count); end
   endtask

   task automatic test_hang();
      start_run();
      step(15);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL hang_early: got %0b expected 0", done); end
      step(1);
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL hang_done: got %0b expected 1", done); end
      tests_run++; if (fail_reason !== 2'd3) begin tests_failed++; $display("FAIL hang_reason: got %0d expected 3", fail_reason); end
      tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL hang_pass: got %0b expected 0", pass); end
      tests_run++; if (cycle_count !== 64'd16) begin tests_failed++; $display("FAIL hang_cycle: got %0d expected 16", cycle_count); end
   endtask

   task automatic test_hang_priority();
      start_run();
      step(15);
      halt_valid = 1'b1;
      halt_code = 32'd0;
      step(1);
      idle_inputs();
      tests_run++; if (fail_reason !== 2'd0) begin tests_failed++; $display("FAIL prio_reason: got %0d expected 0", fail_reason); end
      tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL prio_pass: got %0b expected 1", pass); end
      tests_run++; if (cycle_count !== 64'd16) begin tests_failed++; $display("FAIL prio_cycle: got %0d expected 16", cycle_count); end
      start_run();
      step(15);
      commit_valid = 1'b1;
      step(1);
      commit_valid = 1'b0;
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rescue_done: got %0b expected 0", done); end
      tests_run++; if (inst_count !== 64'd1) begin tests_failed++; $display("FAIL rescue_inst: got %0d expected 1", inst_count); end
      step(15);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rescue_early: got %0b expected 0", done); end
      step(1);
      tests_run++; if (fail_reason !== 2'd3) begin tests_failed++; $display("FAIL rescue_reason: got %0d expected 3", fail_reason); end
      tests_run++; if (cycle_count !== 64'd32) begin tests_failed++; $display("FAIL rescue_cycle: got %0d expected 32", cycle_count); end
   endtask

   task automatic test_timeout();
      start_run();
      commit_valid = 1'b1;
      step(99);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL timeout_early: got %0b expected 0", done); end
      tests_run++; if (cycle_count !== 64'd99) begin tests_failed++; $display("FAIL timeout_cycle_pre: got %0d expected 99", cycle_count); end
      step(1);
      commit_valid = 1'b0;
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL timeout_done: got %0b expected 1", done); end
      tests_run++; if (fail_reason !== 2'd2) begin tests_failed++; $display("FAIL timeout_reason: got %0d expected 2", fail_reason); end
      tests_run++; if (cycle_count !== 64'd100) begin tests_failed++; $display("FAIL timeout_cycle: got %0d expected 100", cycle_count); end
      tests_run++; if (inst_count !== 64'd100) begin tests_failed++; $display("FAIL timeout_inst: got %0d expected 100", inst_count); end
      #2;
      reset_n = 1'b0;
      #1;
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL done_reset_done: got %0b expected 0", done); end
      tests_run++; if (fail_reason !== 2'd0) begin tests_failed++; $display("FAIL done_reset_reason: got %0d expected 0", fail_reason); end
      tests_run++; if (cycle_count !== 64'd0) begin tests_failed++; $display("FAIL done_reset_cycle: got %0d expected 0", cycle_count); end
      tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL done_reset_core: got %0b expected 1", core_reset); end
   endtask

   task automatic test_reset_mid_run();
      start_run();
      commit_valid = 1'b1;
      step(10);
      tests_run++; if (inst_count !== 64'd10) begin tests_failed++; $display("FAIL mid_inst_pre: got %0d expected 10", inst_count); end
      #2;
      reset_n = 1'b0;
      #1;
      tests_run++; if (inst_count !== 64'd0) begin tests_failed++; $display("FAIL mid_inst: got %0d expected 0", inst_count); end
      tests_run++; if (cycle_count !== 64'd0) begin tests_failed++; $display("FAIL mid_cycle: got %0d expected 0", cycle_count); end
      tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL mid_core_reset: got %0b expected 1", core_reset); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mid_done: got %0b expected 0", done); end
      step(1);
      idle_inputs();
   endtask

   task automatic test_history();
      logic [31:0] exp_hist [4];
`ifdef SIM_RUN_MONITOR_PC_HISTORY_EN
      exp_hist = '{32'h8000_0014, 32'h8000_0010, 32'h8000_000C, 32'h8000_0008};
`else
      exp_hist = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
      start_run();
      for (int k = 0; k < 6; k++) begin
         commit_valid = 1'b1;
         commit_pc = 32'h8000_0000 + 32'(4 * k);
         step(1);
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         hist_idx = 2'(i);
         #1;
         tests_run++; if (hist_pc !== exp_hist[i]) begin tests_failed++; $display("FAIL hist_idx%0d: got %08h expected %08h", i, hist_pc, exp_hist[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_pass_run();
      test_bad_code();
      test_hang();
      test_hang_priority();
      test_timeout();
      test_reset_mid_run();
      test_history();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
